// File: rtl/im_fetch_ctrl_if.sv
// Fetch controller bus bundle: instruction-memory read port plus the
// valid/ready instruction stream towards decode.
interface im_fetch_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_data;
    logic              inst_valid;
    logic              inst_ready;
    logic [31:0]       inst;
    logic [ADDR_W-1:0] inst_pc;

    modport master (
        output im_addr,
        input  im_data,
        output inst_valid,
        input  inst_ready,
        output inst,
        output inst_pc
    );

    modport slave (
        input  im_addr,
        output im_data,
        input  inst_valid,
        output inst_ready,
        input  inst,
        input  inst_pc
    );
endinterface

// File: rtl/im_fetch_ctrl.sv
// Instruction fetch sequencer with a small prefetch queue and redirect flush.
// Optional FETCH_PERF_CNT_EN adds saturating stall_cnt / fetch_cnt outputs.
module im_fetch_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int QDEPTH    = 2,
    parameter int MEM_BYTES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [31:0]       prog_len,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    im_fetch_ctrl_if.master   bus,
    output logic              busy,
    output logic              done
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       fetch_cnt
`endif
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [33:0] MEM_LIMIT = 34'(MEM_BYTES);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] limit_q, limit_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [31:0]       q_inst_q [QDEPTH];
    logic [31:0]       q_inst_d [QDEPTH];
    logic [ADDR_W-1:0] q_pc_q   [QDEPTH];
    logic [ADDR_W-1:0] q_pc_d   [QDEPTH];

    logic              inst_valid;
    logic              pop;
    logic              push;
    logic              start_ok;
    logic              redirect_ok;
    logic              can_issue;
    logic [33:0]       len_bytes;
    logic [ADDR_W-1:0] start_limit;
    logic [ADDR_W-1:0] redirect_target;
    logic [CNT_W:0]    occupancy;
    logic [CNT_W:0]    room;

    assign inst_valid     = (count_q != '0);
    assign pop            = inst_valid & bus.inst_ready;
    assign start_ok       = start & ((state_q == IDLE) | (state_q == DONE));
    assign redirect_ok    = redirect & ((state_q == FETCH) | (state_q == DRAIN));
    assign push           = inflight_q & ~redirect_ok & ~start_ok;

    assign len_bytes       = {prog_len, 2'b00};
    assign start_limit     = (len_bytes > MEM_LIMIT) ? ADDR_W'(MEM_BYTES) : ADDR_W'(len_bytes);
    assign redirect_target = redirect_pc & ~ADDR_W'(3);

    // The in-flight word already owns a queue slot, so it counts against capacity.
    assign occupancy = {1'b0, count_q} + (CNT_W+1)'(inflight_q);
    assign room      = (CNT_W+1)'(QDEPTH) + (CNT_W+1)'(pop);
    assign can_issue = (state_q == FETCH) && (fetch_pc_q < limit_q) && (occupancy < room);

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        limit_d       = limit_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        q_inst_d      = q_inst_q;
        q_pc_d        = q_pc_q;

        if (start_ok) begin
            fetch_pc_d = '0;
            limit_d    = start_limit;
            inflight_d = 1'b0;
            state_d    = (start_limit == '0) ? DRAIN : FETCH;
        end else if (redirect_ok) begin
            // Flush wins over everything; the word arriving this cycle is dropped.
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            inflight_d = 1'b0;
            fetch_pc_d = redirect_target;
            state_d    = (redirect_target < limit_q) ? FETCH : DRAIN;
        end else begin
            if (push) begin
                q_inst_d[tail_q] = bus.im_data;
                q_pc_d[tail_q]   = inflight_pc_q;
                tail_d           = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);

            if (can_issue) begin
                inflight_d    = 1'b1;
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + ADDR_W'(4);
            end else begin
                inflight_d = 1'b0;
            end

            case (state_q)
                FETCH:   if (fetch_pc_q >= limit_q) state_d = DRAIN;
                DRAIN:   if ((count_q == '0) && !inflight_q) state_d = DONE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            fetch_pc_q    <= '0;
            limit_q       <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_inst_q[i] <= '0;
                q_pc_q[i]   <= '0;
            end
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            limit_q       <= limit_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            q_inst_q      <= q_inst_d;
            q_pc_q        <= q_pc_d;
        end
    end

    assign bus.im_addr    = fetch_pc_q;
    assign bus.inst_valid = inst_valid;
    assign bus.inst       = q_inst_q[head_q];
    assign bus.inst_pc    = q_pc_q[head_q];
    assign busy           = (state_q == FETCH) | (state_q == DRAIN);
    assign done           = (state_q == DONE);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        fetch_cnt_d = fetch_cnt_q;
        if (start_ok) begin
            stall_cnt_d = '0;
            fetch_cnt_d = '0;
        end else begin
            if (inst_valid && !bus.inst_ready && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + 32'd1;
            end
            if (push && (fetch_cnt_q != '1)) begin
                fetch_cnt_d = fetch_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            fetch_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign fetch_cnt = fetch_cnt_q;
`endif

endmodule

// File: doc/im_fetch_ctrl.md
Name: im_fetch_ctrl

Overview:
Fetch sequencer that drives the byte-addressed instruction memory and delivers instructions to decode.
- Walks a word-aligned fetch PC from 0 up to the program length.
- Absorbs the memory's one-cycle registered read latency.
- Buffers fetched words in a small prefetch queue with a valid/ready handshake.
- Services branch/jump redirects by flushing in-flight and queued work.

Parameters:
ADDR_W, 32, width of the fetch PC and memory address
QDEPTH, 2, prefetch queue entries (power of two, >=2)
MEM_BYTES, 1024, instruction memory size in bytes; fetch never issues at or above this

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins fetch at PC 0 (accepted in IDLE or DONE only)
prog_len  in  32  program length in instructions; sampled on start
redirect  in  1  one-cycle pulse; flush and refetch from redirect_pc
redirect_pc  in  ADDR_W  new fetch byte address; bits [1:0] ignored (forced 0)
im_addr  out  ADDR_W  address to instruction memory; sampled by memory on rising edge
im_data  in  32  memory read data; valid the cycle after im_addr was sampled
inst_valid  out  1  queue head holds an instruction
inst_ready  in  1  decode accepts head this cycle
inst  out  32  head instruction word
inst_pc  out  ADDR_W  byte address of head instruction
busy  out  1  high in FETCH or DRAIN
done  out  1  high in DONE

Behaviour:
- Reset (async, rst_n=0) values:
  - state=IDLE; fetch_pc=0; limit=0; queue empty; inflight=0.
  - im_addr=0, inst_valid=0, inst=0, inst_pc=0, busy=0, done=0.
- Reset mid-operation discards all queued and in-flight data. The first edge after release is IDLE.
- States:
  - IDLE: start -> FETCH; fetch_pc=0; limit=min(prog_len*4, MEM_BYTES).
  - FETCH: issue while fetch_pc<limit. When fetch_pc>=limit -> DRAIN.
  - DRAIN: no issue. Queue empty and inflight=0 -> DONE.
  - DONE: done=1. start -> FETCH, same init as IDLE.
- prog_len=0 on start: go straight to DRAIN, then DONE on the next edge.
- im_addr = fetch_pc at all times (registered).
- Issue at an edge, when state=FETCH, fetch_pc<limit, no redirect, and count + inflight - pop < QDEPTH:
  - inflight<=1; inflight_pc<=fetch_pc; fetch_pc<=fetch_pc+4.
- pop = inst_valid & inst_ready.
- Capture: in the cycle inflight=1, im_data is valid. At the next edge, {im_data, inflight_pc} is written to the queue tail; inflight clears unless a new issue occurs.
- Throughput: one instruction per cycle when inst_ready is held high. Latency from start to first inst_valid is 2 edges.
- The queue never overflows (guaranteed by the issue rule). Push and pop in the same cycle leave count unchanged.
- inst and inst_pc show the queue head, combinationally from queue storage. Both hold stable while inst_valid=1 and inst_ready=0.
- Redirect has priority over pop, issue and capture in the same cycle:
  - queue emptied; inflight=0; the arriving im_data is dropped.
  - fetch_pc<=redirect_pc & ~3.
  - state<=FETCH if the new pc<limit, else DRAIN.
  - Any instruction handshaken in the redirect cycle is still consumed by decode. The controller treats it as flushed; decode owns that ordering.
- Redirect in IDLE or DONE is ignored.
- start while busy is ignored.
- PC arithmetic is modulo 2^ADDR_W. The limit check prevents wrap in practice.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds output ports stall_cnt (32) and fetch_cnt (32).
  - Both clear on reset and on an accepted start.
  - stall_cnt increments each cycle inst_valid=1 and inst_ready=0.
  - fetch_cnt increments on each queue push.
  - Both saturate at 32'hFFFFFFFF.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then start, prog_len=4, memory words W0..W3, inst_ready=1 -> inst_valid from edge 2; inst_pc 0,4,8,12 on consecutive cycles; done=1 two edges after last pop.
- Same program, inst_ready=0 for 5 cycles -> im_addr stops advancing at 8 (QDEPTH=2 full); inst holds W0; no word lost or duplicated on release.
- Redirect to 0x0E with prog_len=8, while a fetch is in flight and the queue holds 2 entries -> queue cleared; next inst_pc=0x0C; stale data never presented.
- Redirect to 0x40 with prog_len=8 -> DRAIN then DONE; inst_valid stays 0.
- rst_n asserted low while 2 entries are queued -> all outputs 0 immediately (async); start afterwards refetches from 0.
- With FETCH_PERF_CNT_EN, 4-instruction run and ready low for 3 cycles -> fetch_cnt=4, stall_cnt=3.
